// File: rtl/arbf_puf_axil_ctrl.sv
// -----------------------------------------------------------------------------
// arbf_puf_axil_ctrl
// AXI4-Lite register bank and evaluation sequencer for the arbiter-butterfly
// PUF core. Software loads a challenge and a repetition count, then starts an
// evaluation. The sequencer applies the challenge, pulses the PUF once per
// repetition, samples the arbiter output after a settle delay and majority-
// votes the samples into a single result bit.
//
// Register map (word address = AxADDR[3:2]):
//   0x00 CTRL   RW  [0] START (write-1 pulse, reads 0), [12:8] REPS
//   0x04 CHAL   RW  [C_CHAL_W-1:0] challenge
//   0x08 STATUS RO  [0] BUSY, [1] DONE, [12:8] ONES
//   0x0C RESULT RO  [0] voted bit, [12:8] number of samples taken
//
// Ports:
//   ACLK, ARESETN        clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*      AXI4-Lite write address / data / response channels
//   S_AXI_AR*/R*         AXI4-Lite read address / data channels
//   puf_chal             challenge held constant during an evaluation
//   puf_excite           one-cycle excitation pulse per repetition
//   puf_resp             arbiter output, sampled once per repetition
// -----------------------------------------------------------------------------
module arbf_puf_axil_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_CHAL_W           = 32,
    parameter int C_SETTLE           = 16,
    parameter int C_RELAX            = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_CHAL_W-1:0]             puf_chal,
    output logic                            puf_excite,
    input  logic                            puf_resp
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CHAL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXCITE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RELAX  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Merge write data into an existing word, one byte lane per strobe bit.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return m;
    endfunction

    // Software-visible registers and AXI channel state
    logic [4:0]          reps_r;
    logic [C_CHAL_W-1:0] chal_r;
    logic                bvalid_r;
    logic                rvalid_r;
    logic [31:0]         rdata_r;

    // Sequencer state
    state_t              state_r;
    logic [15:0]         wait_cnt_r;
    logic [4:0]          rem_r;
    logic [4:0]          ones_r;
    logic [4:0]          samples_r;
    logic                busy_r;
    logic                done_r;
    logic                res_bit_r;
    logic [4:0]          res_cnt_r;
    logic [C_CHAL_W-1:0] chal_out_r;
    logic                excite_r;

    // Decode / datapath
    logic        wr_en_s;
    logic        rd_en_s;
    logic        ctrl_wr_s;
    logic        chal_wr_s;
    logic        start_s;
    logic [31:0] chal_ext_s;
    logic [31:0] ctrl_merge_s;
    logic [31:0] chal_merge_s;
    logic [4:0]  reps_eff_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    // Ready is offered combinationally, so the handshake and the register
    // update share one edge; the pending B/R response closes the window.
    assign wr_en_s       = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_r;
    assign rd_en_s       = S_AXI_ARVALID && !rvalid_r;
    assign S_AXI_AWREADY = wr_en_s;
    assign S_AXI_WREADY  = wr_en_s;
    assign S_AXI_ARREADY = rd_en_s;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata_r;
    assign puf_chal      = chal_out_r;
    assign puf_excite    = excite_r;

    assign ctrl_wr_s = wr_en_s && (S_AXI_AWADDR[3:2] == REG_CTRL);
    assign chal_wr_s = wr_en_s && (S_AXI_AWADDR[3:2] == REG_CHAL);

    // Byte-merged write values for the two writable registers
    always_comb begin
        chal_ext_s                 = 32'h0;
        chal_ext_s[C_CHAL_W-1:0]   = chal_r;
        ctrl_merge_s = byte_merge({19'h0, reps_r, 8'h00}, S_AXI_WDATA, S_AXI_WSTRB);
        chal_merge_s = byte_merge(chal_ext_s, S_AXI_WDATA, S_AXI_WSTRB);
    end

    // START only counts when the sequencer is idle; bit 0 always reads 0, so
    // the merged bit is 1 only when lane 0 is strobed with a 1.
    assign start_s = ctrl_wr_s && ctrl_merge_s[0] && (state_r == ST_IDLE);

    // A repetition count of zero still runs a single evaluation
    always_comb begin
        if (ctrl_merge_s[12:8] == 5'd0) begin
            reps_eff_s = 5'd1;
        end else begin
            reps_eff_s = ctrl_merge_s[12:8];
        end
    end

    // Read-data multiplexer, sampled from pre-write register values
    always_comb begin
        rd_mux_s = 32'h0;
        case (S_AXI_ARADDR[3:2])
            REG_CTRL:   rd_mux_s = {19'h0, reps_r, 8'h00};
            REG_CHAL:   rd_mux_s = chal_ext_s;
            REG_STATUS: rd_mux_s = {19'h0, ones_r, 6'h00, done_r, busy_r};
            REG_RESULT: rd_mux_s = {19'h0, res_cnt_r, 7'h00, res_bit_r};
            default:    rd_mux_s = 32'h0;
        endcase
    end

    // Address LSBs and the unused merge bits carry no meaning here
    assign unused_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], ctrl_merge_s, chal_merge_s};

    // AXI response channels and software-writable registers
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            reps_r   <= 5'd0;
            chal_r   <= '0;
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0;
        end else begin
            if (ctrl_wr_s) begin
                reps_r <= ctrl_merge_s[12:8];
            end
            if (chal_wr_s) begin
                chal_r <= chal_merge_s[C_CHAL_W-1:0];
            end
            if (wr_en_s) begin
                bvalid_r <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
            if (rd_en_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_mux_s;
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Evaluation sequencer: excite, settle, sample, relax, then vote
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 16'd0;
            rem_r      <= 5'd0;
            ones_r     <= 5'd0;
            samples_r  <= 5'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            res_bit_r  <= 1'b0;
            res_cnt_r  <= 5'd0;
            chal_out_r <= '0;
            excite_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    excite_r <= 1'b0;
                    if (start_s) begin
                        chal_out_r <= chal_r;
                        rem_r      <= reps_eff_s;
                        ones_r     <= 5'd0;
                        samples_r  <= 5'd0;
                        done_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        excite_r   <= 1'b1;
                        state_r    <= ST_EXCITE;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_EXCITE: begin
                    excite_r   <= 1'b0;
                    wait_cnt_r <= 16'(C_SETTLE - 1);
                    state_r    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (wait_cnt_r == 16'd0) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    ones_r    <= ones_r + {4'd0, puf_resp};
                    samples_r <= samples_r + 5'd1;
                    rem_r     <= rem_r - 5'd1;
                    if (rem_r == 5'd1) begin
                        state_r <= ST_FINISH;
                    end else begin
                        wait_cnt_r <= 16'(C_RELAX - 1);
                        state_r    <= ST_RELAX;
                    end
                end
                ST_RELAX: begin
                    if (wait_cnt_r == 16'd0) begin
                        excite_r <= 1'b1;
                        state_r  <= ST_EXCITE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 16'd1;
                    end
                end
                ST_FINISH: begin
                    // Strict majority: a tie votes 0
                    res_bit_r <= ({ones_r, 1'b0} > {1'b0, samples_r});
                    res_cnt_r <= samples_r;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    excite_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbf_puf_axil_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for arbf_puf_axil_ctrl: a table of register-access vectors followed
// by hand-written evaluation sequences with hand-computed timing and results
// (defaults: C_SETTLE=16, C_RELAX=8, so one repetition is 18 cycles and
// excite pulses are 26 cycles apart).
// -----------------------------------------------------------------------------
module tb_arbf_puf_axil_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] puf_chal;
    logic        puf_excite;
    logic        puf_resp = 1'b0;

    arbf_puf_axil_ctrl dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .puf_chal      (puf_chal),
        .puf_excite    (puf_excite),
        .puf_resp      (puf_resp)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Excite monitor: counts pulses, records their cycle, feeds responses
    int         exc_cnt  = 0;
    int         wide_err = 0;
    int         exc_cyc [0:63];
    logic       prev_exc = 1'b0;
    logic [7:0] resp_tab = 8'h00;
    int         exc_base = 0;

    always @(negedge ACLK) begin
        if (puf_excite) begin
            exc_cyc[exc_cnt[5:0]] <= cyc;
            exc_cnt  <= exc_cnt + 1;
            puf_resp <= resp_tab[3'(exc_cnt - exc_base)];
        end
        if (puf_excite && prev_exc) wide_err <= wide_err + 1;
        prev_exc <= puf_excite;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int acc, output logic [1:0] br);
        int n;
        acc = -1;
        br  = 2'b11;
        @(negedge ACLK);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        #1;
        n = 0;
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        if (n >= 50) chk("wr_accept_timeout", 32'd0, 32'd1);
        else acc = cyc + 1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 50) begin
            @(negedge ACLK); n++;
        end
        if (S_AXI_BVALID) br = S_AXI_BRESP;
        else chk("bvalid_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
    endtask

    // tgt > 0 forces the read address to be accepted on edge number tgt
    task automatic axi_rd(input logic [3:0] a, input int tgt,
                          output logic [31:0] d, output logic [1:0] rr);
        int n;
        int acc;
        d  = 32'hxxxx_xxxx;
        rr = 2'b11;
        @(negedge ACLK);
        while (cyc < tgt - 1) @(negedge ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        #1;
        n = 0;
        while (!S_AXI_ARREADY && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        acc = cyc + 1;
        if (n >= 50) chk("rd_accept_timeout", 32'd0, 32'd1);
        if (tgt > 0) chk("rd_accept_edge", 32'(acc), 32'(tgt));
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        if (S_AXI_RVALID) begin
            d = S_AXI_RDATA; rr = S_AXI_RRESP;
        end else begin
            chk("rvalid_missing", 32'd0, 32'd1);
        end
        @(posedge ACLK); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          b;
        int          bv_bad;
        int          aw_bad;
        logic [1:0]  rsp;
        logic [31:0] rd;

        //            wr     addr   data           strb   exp
        vt[0]  = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h0};
        vt[1]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h0};
        vt[2]  = '{1'b0, 4'h8, 32'h0,          4'h0, 32'h0};
        vt[3]  = '{1'b0, 4'hC, 32'h0,          4'h0, 32'h0};
        vt[4]  = '{1'b1, 4'h4, 32'hDEADBEEF,   4'h3, 32'h0};
        vt[5]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h0000BEEF};
        vt[6]  = '{1'b1, 4'h4, 32'hDEADBEEF,   4'hF, 32'h0};
        vt[7]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'hDEADBEEF};
        vt[8]  = '{1'b1, 4'h8, 32'hFFFFFFFF,   4'hF, 32'h0};
        vt[9]  = '{1'b0, 4'h8, 32'h0,          4'h0, 32'h0};
        vt[10] = '{1'b1, 4'hC, 32'hFFFFFFFF,   4'hF, 32'h0};
        vt[11] = '{1'b0, 4'hC, 32'h0,          4'h0, 32'h0};
        vt[12] = '{1'b1, 4'h0, 32'h00001F00,   4'h1, 32'h0};
        vt[13] = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h0};
        vt[14] = '{1'b1, 4'h0, 32'hFFFF1F00,   4'hF, 32'h0};
        vt[15] = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h00001F00};

        ARESETN = 1'b0;
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        repeat (5) @(negedge ACLK);
        chk("rst_excite", {31'd0, puf_excite}, 32'd0);
        chk("rst_chal",   puf_chal, 32'd0);
        chk("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        chk("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        ARESETN = 1'b1;

        // Register-access vectors
        for (int i = 0; i < NV; i++) begin
            if (vt[i].wr) begin
                axi_wr(vt[i].addr, vt[i].data, vt[i].strb, acc, rsp);
                chk($sformatf("vec%0d_bresp", i), {30'd0, rsp}, 32'd0);
            end else begin
                axi_rd(vt[i].addr, 0, rd, rsp);
                chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
                chk($sformatf("vec%0d_rresp", i), {30'd0, rsp}, 32'd0);
            end
        end
        chk("no_excite_yet", 32'(exc_cnt), 32'd0);
        chk("chal_not_latched", puf_chal, 32'd0);

        // REPS=1, response 1: DONE appears on edge acc+19
        b = exc_cnt; exc_base = exc_cnt; resp_tab = 8'h01;
        axi_wr(4'h0, 32'h00000101, 4'hF, acc, rsp);
        axi_rd(4'h8, acc + 19, rd, rsp);
        chk("r1_status_busy", rd, 32'h00000101);
        axi_rd(4'h8, acc + 21, rd, rsp);
        chk("r1_status_done", rd, 32'h00000102);
        axi_rd(4'hC, 0, rd, rsp);
        chk("r1_result", rd, 32'h00000101);
        chk("r1_pulses", 32'(exc_cnt - b), 32'd1);
        chk("r1_pulse_cycle", 32'(exc_cyc[b]), 32'(acc));
        chk("r1_puf_chal", puf_chal, 32'hDEADBEEF);

        // REPS=5, responses 1,0,1,1,0: 5*18+4*8+1 = 123 cycles
        b = exc_cnt; exc_base = exc_cnt; resp_tab = 8'h0D;
        axi_wr(4'h0, 32'h00000501, 4'hF, acc, rsp);
        axi_rd(4'h8, acc + 130, rd, rsp);
        chk("r5_status", rd, 32'h00000302);
        axi_rd(4'hC, 0, rd, rsp);
        chk("r5_result", rd, 32'h00000501);
        chk("r5_pulses", 32'(exc_cnt - b), 32'd5);
        for (int i = 0; i < 4; i++)
            chk($sformatf("r5_spacing%0d", i), 32'(exc_cyc[b+i+1] - exc_cyc[b+i]), 32'd26);

        // REPS=4, responses 1,1,0,0: tie votes 0
        b = exc_cnt; exc_base = exc_cnt; resp_tab = 8'h03;
        axi_wr(4'h0, 32'h00000401, 4'hF, acc, rsp);
        axi_rd(4'h8, acc + 105, rd, rsp);
        chk("r4_status", rd, 32'h00000202);
        axi_rd(4'hC, 0, rd, rsp);
        chk("r4_result_tie", rd, 32'h00000400);
        chk("r4_pulses", 32'(exc_cnt - b), 32'd4);

        // REPS=0 runs a single evaluation
        b = exc_cnt; exc_base = exc_cnt; resp_tab = 8'h01;
        axi_wr(4'h0, 32'h00000001, 4'hF, acc, rsp);
        axi_rd(4'hC, acc + 25, rd, rsp);
        chk("r0_result", rd, 32'h00000101);
        chk("r0_pulses", 32'(exc_cnt - b), 32'd1);

        // START and CHAL writes while busy (REPS=2 run)
        b = exc_cnt; exc_base = exc_cnt; resp_tab = 8'h00;
        axi_wr(4'h0, 32'h00000201, 4'hF, acc, rsp);
        axi_wr(4'h4, 32'h12345678, 4'hF, b, rsp);
        b = exc_base;
        axi_wr(4'h0, 32'h00000301, 4'hF, b, rsp);
        b = exc_base;
        chk("busy_puf_chal", puf_chal, 32'hDEADBEEF);
        axi_rd(4'h4, 0, rd, rsp);
        chk("busy_chal_reg", rd, 32'h12345678);
        axi_rd(4'h0, 0, rd, rsp);
        chk("busy_reps_upd", rd, 32'h00000300);
        axi_rd(4'hC, acc + 60, rd, rsp);
        chk("busy_result", rd, 32'h00000200);
        axi_rd(4'h8, 0, rd, rsp);
        chk("busy_status", rd, 32'h00000002);
        chk("busy_no_restart", 32'(exc_cnt - b), 32'd2);
        chk("busy_puf_chal_end", puf_chal, 32'hDEADBEEF);

        // BREADY held low: BVALID holds, a second write is not accepted
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h11111111; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        #1;
        chk("bp_first_accept", {31'd0, S_AXI_AWREADY}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_WDATA = 32'hCAFEF00D;
        bv_bad = 0; aw_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK); #1;
            if (!S_AXI_BVALID) bv_bad++;
            if (S_AXI_AWREADY || S_AXI_WREADY) aw_bad++;
        end
        chk("bp_bvalid_held", 32'(bv_bad), 32'd0);
        chk("bp_awready_low", 32'(aw_bad), 32'd0);
        S_AXI_BREADY = 1'b1;
        b = 0;
        while (!S_AXI_AWREADY && b < 20) begin
            @(negedge ACLK); #1; b++;
        end
        chk("bp_second_accept", {31'd0, S_AXI_AWREADY}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(posedge ACLK); #1;
        axi_rd(4'h4, 0, rd, rsp);
        chk("bp_chal", rd, 32'hCAFEF00D);

        // Reset in the middle of SETTLE aborts the run
        b = exc_cnt; exc_base = exc_cnt; resp_tab = 8'h07;
        axi_wr(4'h0, 32'h00000301, 4'hF, acc, rsp);
        while (cyc < acc + 5) @(negedge ACLK);
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (100) @(negedge ACLK);
        chk("rst_mid_pulses", 32'(exc_cnt - b), 32'd1);
        axi_rd(4'h8, 0, rd, rsp);
        chk("rst_mid_status", rd, 32'h0);
        axi_rd(4'hC, 0, rd, rsp);
        chk("rst_mid_result", rd, 32'h0);
        axi_rd(4'h4, 0, rd, rsp);
        chk("rst_mid_chal", rd, 32'h0);
        chk("rst_mid_puf_chal", puf_chal, 32'h0);
        chk("excite_width", 32'(wide_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/arbf_puf_axil_ctrl.md
Name: arbf_puf_axil_ctrl

Overview:
AXI4-Lite slave register bank and evaluation sequencer for the arbiter-butterfly PUF core. It sits directly between the AXI interconnect, which is driven by the master VIP in the IP bench, and the PUF core. Software writes a challenge and a repetition count, then starts an evaluation. The block drives the challenge, excites the PUF repeatedly, majority-votes the sampled response bits, and exposes status and result as read-back registers.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, AXI address width; 4 word registers
C_CHAL_W, 32, challenge width driven to the PUF (≤32)
C_SETTLE, 16, cycles between excite pulse and response sample (≥1)
C_RELAX, 8, idle cycles between evaluations (≥1)

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
S_AXI_AWADDR  in  4  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  always 2'b00
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  4  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
puf_chal  out  C_CHAL_W  challenge applied to the PUF
puf_excite  out  1  one-cycle excitation pulse
puf_resp  in  1  arbiter output; sampled only in SAMPLE

Behaviour:
- Clock and reset: one clock, ACLK. Reset is synchronous and active-low on ARESETN.
- Reset values: all outputs 0, all registers 0, FSM in IDLE. Reset mid-evaluation aborts the evaluation; no excite pulse is issued after reset.
- Register decode, AWADDR/ARADDR[3:2]:
  - 0x00 CTRL (RW): [0] START, write-1 pulse that reads as 0; [12:8] REPS.
  - 0x04 CHAL (RW): [C_CHAL_W-1:0].
  - 0x08 STATUS (RO): [0] BUSY, [1] DONE, [12:8] ONES.
  - 0x0C RESULT (RO): [0] voted bit, [12:8] count of samples taken.
  - Writes to RO registers are dropped and answered OKAY. Unused bits read 0.
- Write channel:
  - AWREADY and WREADY pulse high together for one cycle when AWVALID && WVALID && !BVALID.
  - Register update occurs on that same edge, honouring WSTRB per byte.
  - BVALID rises the next cycle and holds until BREADY.
  - AW without W, or W without AW: no accept; wait for the other.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID && !RVALID.
  - RDATA is registered; RVALID rises the next cycle and RDATA is held stable until RREADY.
- Read/write collision: simultaneous read and write are both accepted; the read returns the pre-write value.
- START while BUSY is ignored; the REPS field is still updated.
- CHAL writes while BUSY update the register only. puf_chal is latched at START and is constant for the whole evaluation.
- Sequencer FSM:
  - IDLE → EXCITE on accepted START. At this transition: latch chal, set rem = (REPS==0 ? 1 : REPS), clear ONES, clear DONE, set BUSY=1.
  - EXCITE: puf_excite=1 for exactly 1 cycle → SETTLE.
  - SETTLE: count C_SETTLE cycles → SAMPLE.
  - SAMPLE (1 cycle): ONES += puf_resp; rem -= 1. If rem becomes 0 → FINISH, else → RELAX.
  - RELAX: C_RELAX cycles → EXCITE.
  - FINISH (1 cycle): voted = (2*ONES > total), so a tie gives 0. Write RESULT, set DONE=1 and BUSY=0 → IDLE.
- Per-evaluation latency: 1 + C_SETTLE + 1 cycles. Total from START accept to DONE = N*(C_SETTLE+2) + (N-1)*C_RELAX + 1 cycles.
- Counter widths: ONES and the sample counter are 5 bits, so maximum REPS is 31 with no wrap. DONE is sticky until the next accepted START.

Test Plan:
- Reset then read 0x00..0x0C → RDATA 0, RRESP 0, puf_excite never asserted.
- Write CHAL=0xDEADBEEF, WSTRB=4'b0011 → read back 0x0000BEEF; WSTRB=4'hF → 0xDEADBEEF. Write 0x08 → BRESP 0, value unchanged.
- REPS=1, START, puf_resp held 1 → exactly 1 excite pulse. DONE after C_SETTLE+3 cycles (19 at defaults); RESULT=0x101, STATUS=0x102.
- REPS=5, responses 1,0,1,1,0 → 5 excite pulses spaced C_SETTLE+2+C_RELAX = 26 cycles apart; ONES=3, RESULT[0]=1.
- REPS=4, responses 1,1,0,0 → RESULT[0]=0 (tie). REPS=0 → one evaluation.
- START and CHAL write during BUSY → puf_chal unchanged, no restart. BREADY held low 10 cycles → BVALID held, AWREADY stays 0. ARESETN low mid-SETTLE → BUSY=0, no further excite.
